dac_spi_frame_receiver: RTL
===========================

// Module: dac_spi_frame_receiver
// PURPOSE
//  Receiving end of the 4-channel DAC SPI link: captures 16-bit frames from o_ClkDac/o_CsDac[1:0]/o_dataDac,
//  decodes chip/channel and 8-bit code, and updates a 32-bit shadow word in the same lane layout as the
//  transmitter's i_data. Used for on-chip loopback checking and readback of the last code sent to each DAC.
//  All SPI inputs are oversampled in the i_clk domain; no SCLK-clocked logic.
// PARAMETERS
//  SYNC_STAGES  2     synchronizer depth on i_SClk, i_Cs[1:0], i_Sdi (>=2)
//  FRAME_BITS   16    bits per frame, MSB first
//  TIMEOUT_CYC  1023  i_clk cycles with CS low and no SCLK rise before the frame is aborted
// PORTS
//  i_clk       in   1   system clock, >= 4x SCLK rate
//  i_rst       in   1   async active-high reset
//  i_SClk      in   1   SPI clock; idle low, data stable on rising edge
//  i_Cs        in   2   chip selects, active low; [1] = chip A (ch0/ch1), [0] = chip B (ch2/ch3)
//  i_Sdi       in   1   serial data, MSB first
//  o_valid     out  1   1-cycle pulse: good frame received
//  o_ch        out  2   channel of last good frame (0..3)
//  o_code      out  8   8-bit code of last good frame
//  o_word      out  16  raw 16-bit word of last frame (good or bad)
//  o_shadow    out  32  {ch3,ch2,ch1,ch0} codes, updated per good frame
//  o_err       out  1   1-cycle pulse: frame rejected
//  o_err_code  out  3   reason for last rejection: 1 short, 2 long, 3 format, 4 both CS, 5 timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, bit counter 0, shift register 0.
//  Inputs pass through SYNC_STAGES flops; edges are detected on the last synced stage against a 1-cycle-delayed copy.
//  FSM: IDLE -> SHIFT when exactly one synced CS falls low (sel latched: A if Cs[1] low, B if Cs[0] low).
//   Both CS low at once (either in IDLE or during SHIFT) -> ERR code 4.
//   SHIFT: on each synced SCLK rise, shift Sdi in at LSB and increment the bit count (saturates at FRAME_BITS+1).
//   SHIFT: timeout counter clears on each SCLK rise; reaching TIMEOUT_CYC -> ERR code 5.
//   SHIFT: latched CS rises -> CHECK.
//   CHECK (1 cycle): count < 16 -> ERR 1; count > 16 -> ERR 2;
//    word[14:12] != 3'b111 or word[3:0] != 4'b0011 -> ERR 3; otherwise -> GOOD.
//   GOOD: o_valid=1; o_code=word[11:4]; o_ch = {sel==B, ~word[15]}, so bit15=1 selects even ch and bit15=0 odd.
//    Write o_shadow[8*o_ch +: 8] = code. Then -> IDLE.
//   ERR: o_err=1 and o_err_code set; o_shadow/o_ch/o_code unchanged. Then -> WAIT_IDLE.
//   WAIT_IDLE holds until both synced CS are high, then -> IDLE.
//  o_word loads the shift register on every entry to CHECK.
//  Latency: o_valid/o_err is asserted 2 i_clk cycles after the synced CS rise is detected.
//  Frames are back to back with no gap requirement beyond 1 synced CS-high sample.
//  An SCLK rise in the same cycle as the CS rise is counted before CHECK.
//  SCLK edges while in IDLE or WAIT_IDLE are ignored.
//  Reset asserted mid-frame aborts immediately with no pulse. After release, the FSM waits in IDLE for a fresh CS fall.
// TESTING
//  1. Cs=2'b01, word 16'hFA53 (bit15=1, code 0xA5) -> o_valid, o_ch=0, o_code=A5, o_shadow[7:0]=A5.
//  2. Four frames in transmitter order with codes 11,22,33,44 -> o_shadow=32'h44332211, four o_valid pulses, no o_err.
//  3. 15 SCLK then CS rise -> o_err, o_err_code=1, shadow unchanged. Same with 17 SCLK -> o_err_code=2.
//  4. word 16'hF5A0 (low nibble 0) -> o_err_code=3. Cs=2'b00 -> o_err_code=4 and no o_valid until both CS high.
//  5. CS low with 5 SCLK then stall 1100 cycles -> o_err_code=5 at cycle TIMEOUT_CYC; next valid frame is accepted.
//  6. Assert i_rst after bit 8 -> outputs zero. Full frame after release -> o_valid with correct o_ch/o_code.

Source files
------------

// File: rtl/dac_spi_frame_receiver.sv
// Oversampled receiver for the 4-channel DAC SPI link. It decodes 16-bit frames into
// channel/code pairs and keeps a shadow copy of the last code sent to each channel.
module dac_spi_frame_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_SClk,
  input  logic [1:0]  i_Cs,
  input  logic        i_Sdi,
  output logic        o_valid,
  output logic [1:0]  o_ch,
  output logic [7:0]  o_code,
  output logic [15:0] o_word,
  output logic [31:0] o_shadow,
  output logic        o_err,
  output logic [2:0]  o_err_code
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 2);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    StIdle, StShift, StCheck, StGood, StErr, StWaitIdle
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  csa_sync_q, csa_sync_d;
  logic [SYNC_STAGES-1:0]  csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0]  sdi_sync_q, sdi_sync_d;
  logic                    sclk_dly_q, sclk_dly_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic                    sel_q, sel_d;    // 1 = chip B (ch2/ch3)
  logic                    arm_q, arm_d;    // both CS seen high since last frame start
  logic [15:0]             word_q, word_d;
  logic [1:0]              ch_q, ch_d;
  logic [7:0]              code_q, code_d;
  logic [31:0]             shadow_q, shadow_d;
  logic [2:0]              err_code_q, err_code_d;

  logic [1:0] cs_s;
  logic       sclk_s, sdi_s, sclk_rise, cs_rise;
  logic [1:0] ch_new;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s      = {csa_sync_q[SYNC_STAGES-1], csb_sync_q[SYNC_STAGES-1]};
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign cs_rise   = sel_q ? cs_s[0] : cs_s[1];
  assign ch_new    = {sel_q, ~shift_q[15]};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_SClk};
    csa_sync_d  = {csa_sync_q[SYNC_STAGES-2:0], i_Cs[1]};
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], i_Cs[0]};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], i_Sdi};
    sclk_dly_d  = sclk_s;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    sel_d      = sel_q;
    arm_d      = arm_q;
    word_d     = word_q;
    ch_d       = ch_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    err_code_d = err_code_q;
    if (cs_s == 2'b11) arm_d = 1'b1;

    case (state_q)
      StIdle: begin
        // Unarmed after reset so a frame already in flight is never picked up halfway.
        if (arm_q && cs_s == 2'b00) begin
          state_d    = StErr;
          err_code_d = 3'd4;
        end else if (arm_q && cs_s != 2'b11) begin
          state_d = StShift;
          sel_d   = ~cs_s[0];
          arm_d   = 1'b0;
          shift_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      StShift: begin
        if (cs_s == 2'b00) begin
          state_d    = StErr;
          err_code_d = 3'd4;
        end else begin
          if (sclk_rise) begin
            shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
            if (cnt_q != CntW'(FRAME_BITS + 1)) cnt_d = cnt_q + CntW'(1);
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
          if (cs_rise) begin
            state_d = StCheck;
            word_d  = shift_d;
          end else if (!sclk_rise && tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            state_d    = StErr;
            err_code_d = 3'd5;
          end
        end
      end
      StCheck: begin
        if (cnt_q < CntW'(FRAME_BITS)) begin
          state_d    = StErr;
          err_code_d = 3'd1;
        end else if (cnt_q > CntW'(FRAME_BITS)) begin
          state_d    = StErr;
          err_code_d = 3'd2;
        end else if (shift_q[14:12] != 3'b111 || shift_q[3:0] != 4'b0011) begin
          state_d    = StErr;
          err_code_d = 3'd3;
        end else begin
          state_d                        = StGood;
          ch_d                           = ch_new;
          code_d                         = shift_q[11:4];
          shadow_d[{ch_new, 3'b000} +: 8] = shift_q[11:4];
        end
      end
      StGood:     state_d = StIdle;
      StErr:      state_d = StWaitIdle;
      StWaitIdle: if (cs_s == 2'b11) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // CS synchronizers reset low so the FSM stays unarmed until CS is genuinely seen high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      sclk_sync_q <= '0;
      csa_sync_q  <= '0;
      csb_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      sel_q       <= 1'b0;
      arm_q       <= 1'b0;
      word_q      <= '0;
      ch_q        <= '0;
      code_q      <= '0;
      shadow_q    <= '0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      csa_sync_q  <= csa_sync_d;
      csb_sync_q  <= csb_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      sel_q       <= sel_d;
      arm_q       <= arm_d;
      word_q      <= word_d;
      ch_q        <= ch_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
      err_code_q  <= err_code_d;
    end
  end

  assign o_valid    = (state_q == StGood);
  assign o_err      = (state_q == StErr);
  assign o_ch       = ch_q;
  assign o_code     = code_q;
  assign o_word     = word_q;
  assign o_shadow   = shadow_q;
  assign o_err_code = err_code_q;

endmodule
